// File: rtl/seq_scan_ctrl.sv
// Serial pattern-scan controller: takes words on a valid/ready handshake, shifts them
// MSB-first through a PAT_W-bit history, counts pattern hits and halts at a threshold.
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              done
);

  localparam int BC_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   pattern_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   thresh_q;
  logic [DATA_W-1:0]  sreg;
  logic [PAT_W-1:0]   hist;
  logic [FILL_W-1:0]  fill;
  logic [BC_W-1:0]    bit_cnt;

  logic               accept;
  logic               cfg_load;
  logic [PAT_W-1:0]   cand;
  logic               hit;
  logic [CNT_W-1:0]   cnt_inc;
  logic [FILL_W-1:0]  fill_inc;

  assign accept   = in_valid && in_ready;
  assign cfg_load = cfg_we && !clear && (state == IDLE);
  assign cand     = {hist[PAT_W-2:0], sreg[DATA_W-1]};
  // fill counts bits already in the history; PAT_W-1 old bits plus the current one form a full window
  assign hit      = (state == SHIFT) && (cand == pattern_q) &&
                    (fill >= FILL_W'(PAT_W - 1));
  assign cnt_inc  = (match_count == {CNT_W{1'b1}}) ? match_count : match_count + 1'b1;
  assign fill_inc = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = SHIFT;
        SHIFT:   if (bit_cnt == '0 && !accept) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: every output written here gets a default assignment, so no latch can be inferred.
  always_comb begin
    busy     = (state == SHIFT);
    in_ready = !clear && !done && ((state == IDLE) || (bit_cnt == '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q   <= '0;
      overlap_q   <= 1'b0;
      thresh_q    <= '0;
      sreg        <= '0;
      hist        <= '0;
      fill        <= '0;
      bit_cnt     <= '0;
      match_pulse <= 1'b0;
      match_count <= '0;
      done        <= 1'b0;
    end else if (clear) begin
      // abort keeps the programmed configuration
      sreg        <= '0;
      hist        <= '0;
      fill        <= '0;
      bit_cnt     <= '0;
      match_pulse <= 1'b0;
      match_count <= '0;
      done        <= 1'b0;
    end else begin
      match_pulse <= hit;
      if (cfg_load) begin
        pattern_q   <= cfg_pattern;
        overlap_q   <= cfg_overlap;
        thresh_q    <= cfg_thresh;
        match_count <= '0;
        hist        <= '0;
        fill        <= '0;
        done        <= 1'b0;
      end
      if (state == SHIFT) begin
        sreg <= sreg << 1;
        hist <= cand;
        fill <= (hit && !overlap_q) ? '0 : fill_inc;
        if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
        if (hit) begin
          match_count <= cnt_inc;
          if (thresh_q != '0 && cnt_inc == thresh_q) done <= 1'b1;
        end
      end
      // a word accepted on the last bit reloads the shifter with no idle gap
      if (accept) begin
        sreg    <= in_data;
        bit_cnt <= BC_W'(DATA_W - 1);
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: table of single-word scans plus hand-written
// sequences for streaming, threshold halt, clear, async reset and saturation.
module tb_seq_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic [7:0] cfg_thresh;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       match_pulse;
  logic [7:0] match_count;
  logic       done;

  int total = 0;
  int bad   = 0;

  seq_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pattern;
    logic       overlap;
    logic [7:0] thresh;
    logic [7:0] word;
    logic [8:0] pulse_mask;  // bit k: match_pulse expected after the k-th edge past the accept
    logic [7:0] exp_count;
    int         done_at;     // first sample index with done=1, -1 if never
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [3:0] p, input logic ov, input logic [7:0] th);
    cfg_we = 1'b1; cfg_pattern = p; cfg_overlap = ov; cfg_thresh = th;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0110, 1'b1, 8'd0, 8'b0110_1100, 9'h090, 8'd2, -1};
    vecs[1] = '{4'b0110, 1'b0, 8'd0, 8'b0110_1100, 9'h010, 8'd1, -1};
    vecs[2] = '{4'b1010, 1'b1, 8'd0, 8'b1010_1010, 9'h150, 8'd3, -1};
    vecs[3] = '{4'b1010, 1'b0, 8'd0, 8'b1010_1010, 9'h110, 8'd2, -1};
    vecs[4] = '{4'b0000, 1'b1, 8'd0, 8'b0000_0000, 9'h1F0, 8'd5, -1};
    vecs[5] = '{4'b1111, 1'b1, 8'd3, 8'b1111_1111, 9'h1F0, 8'd5, 6};
    vecs[6] = '{4'b1111, 1'b1, 8'd0, 8'b1111_0000, 9'h010, 8'd1, -1};
    vecs[7] = '{4'b0110, 1'b1, 8'd2, 8'b0110_0110, 9'h110, 8'd2, 8};

    reset = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0; cfg_thresh = '0;
    clear = 1'b0; in_valid = 1'b0; in_data = '0;

    #3;
    check("rst busy", busy, 0);
    check("rst pulse", match_pulse, 0);
    check("rst count", match_count, 0);
    check("rst done", done, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    check("post-rst ready", in_ready, 1);

    // table: plain cfg, then cfg together with an accept so the first bit sees the new config
    for (int i = 0; i < 8; i++) begin
      do_cfg(vecs[i].pattern, vecs[i].overlap, vecs[i].thresh);
      cfg_we = 1'b1; in_valid = 1'b1; in_data = vecs[i].word;
      check($sformatf("vec%0d ready", i), in_ready, 1);
      tick();
      cfg_we = 1'b0; in_valid = 1'b0;
      check($sformatf("vec%0d count0", i), match_count, 0);
      for (int k = 0; k <= 8; k++) begin
        if (k > 0) tick();
        check($sformatf("vec%0d k%0d busy", i, k), busy, (k < 8));
        check($sformatf("vec%0d k%0d pulse", i, k), match_pulse, vecs[i].pulse_mask[k]);
        check($sformatf("vec%0d k%0d done", i, k), done,
              (vecs[i].done_at >= 0 && k >= vecs[i].done_at));
      end
      check($sformatf("vec%0d count", i), match_count, vecs[i].exp_count);
    end

    // halted after threshold: offered words are refused until reconfigured
    in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      check("halt ready", in_ready, 0);
      tick();
      check("halt busy", busy, 0);
      check("halt done", done, 1);
      check("halt count", match_count, 2);
    end
    in_valid = 1'b0;
    do_cfg(4'b0110, 1'b1, 8'd0);
    check("recfg done", done, 0);
    check("recfg count", match_count, 0);
    check("recfg ready", in_ready, 1);

    // back-to-back words: hit straddles the word boundary
    in_valid = 1'b1; in_data = 8'b0000_0011;
    tick();
    in_data = 8'b0000_0000;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("xw k%0d busy", k), busy, 1);
      check($sformatf("xw k%0d ready", k), in_ready, (k == 7 || k == 15));
      check($sformatf("xw k%0d pulse", k), match_pulse, (k == 9));
      if (k == 8) in_valid = 1'b0;
      tick();
    end
    check("xw idle", busy, 0);
    check("xw count", match_count, 1);

    // clear on the last bit with a word offered: word refused, counters zeroed
    in_valid = 1'b1; in_data = 8'b0110_1100;
    tick();
    repeat (7) tick();
    check("pre-clr ready", in_ready, 1);
    check("pre-clr count", match_count, 3);
    clear = 1'b1;
    #1;
    check("clr ready", in_ready, 0);
    tick();
    check("clr busy", busy, 0);
    check("clr count", match_count, 0);
    check("clr done", done, 0);
    check("clr pulse", match_pulse, 0);
    clear = 1'b0; in_valid = 1'b0;
    #1;
    check("post-clr ready", in_ready, 1);

    // config retained across clear; cfg_we during SHIFT ignored
    in_valid = 1'b1; in_data = 8'b0110_1100;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b0; cfg_thresh = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      cfg_we = 1'b0;
      check($sformatf("ign k%0d pulse", k), match_pulse, (k == 4 || k == 7));
      check($sformatf("ign k%0d done", k), done, 0);
    end
    check("ign count", match_count, 2);

    // asynchronous reset in the middle of a word
    do_cfg(4'b1111, 1'b1, 8'd1);
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("pre-rst done", done, 1);
    check("pre-rst count", match_count, 2);
    #2 reset = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst pulse", match_pulse, 0);
    check("arst count", match_count, 0);
    check("arst done", done, 0);
    @(negedge clk) reset = 1'b1;
    #1;
    check("arst ready", in_ready, 1);

    // reset config is pattern 0000, no overlap, no threshold
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("zcfg k%0d pulse", k), match_pulse, (k == 4 || k == 8));
    end
    check("zcfg count", match_count, 2);
    check("zcfg done", done, 0);

    // counter saturates at all-ones
    do_cfg(4'b0000, 1'b1, 8'd0);
    in_valid = 1'b1; in_data = 8'h00;
    repeat (34 * 8) tick();
    in_valid = 1'b0;
    repeat (12) tick();
    check("sat count", match_count, 8'hFF);
    check("sat busy", busy, 0);
    check("sat done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Controller that sequences a programmable serial pattern detector over a parallel input stream.
- Accepts DATA_W-bit words on a valid/ready handshake and serialises them MSB-first, one bit per clock, into a PAT_W-bit history/compare engine.
- Counts pattern hits and halts the stream when a programmed threshold is reached.
- Sits between a word-oriented producer and the serial detection path, and owns its configuration.

Parameters:
DATA_W, 8, width of input word / bits serialised per accepted word
PAT_W, 4, pattern length in bits (fixed per instance)
CNT_W, 8, width of match counter and threshold

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
cfg_we  input  1  configuration write strobe, honoured only in IDLE
cfg_pattern  input  PAT_W  pattern to detect; bit PAT_W-1 is the oldest bit
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history restarts after a hit
cfg_thresh  input  CNT_W  hit count that halts the block; 0 = never halt
clear  input  1  synchronous abort/clear, any state
in_valid  input  1  word available
in_data  input  DATA_W  word, MSB serialised first
in_ready  output  1  word accepted on cycle with in_valid&&in_ready
busy  output  1  high in SHIFT
match_pulse  output  1  one-cycle pulse per detected hit
match_count  output  CNT_W  saturating hit count
done  output  1  threshold reached; stream halted

Behaviour:
- Reset (reset=0, async): state=IDLE; pattern=0, overlap=0, thresh=0; shift reg, history and fill=0; bit_cnt=0; match_pulse=0, match_count=0, done=0, busy=0.
- States: IDLE, SHIFT. bit_cnt counts DATA_W-1 down to 0.
- in_ready (combinational) = !clear && !done && (state==IDLE || (state==SHIFT && bit_cnt==0)).
- Accept (in_valid&&in_ready): load shift reg with in_data, bit_cnt=DATA_W-1, state=SHIFT. Back-to-back words give gap-free streaming at DATA_W cycles/word.
- SHIFT, each cycle:
  - b = shift reg MSB; shift reg <<= 1.
  - cand = {hist[PAT_W-2:0], b}; hist <= cand; fill <= min(fill+1, PAT_W).
  - If bit_cnt==0 and no accept: go to IDLE; else bit_cnt decrements.
- Hit: cand==pattern && fill>=PAT_W-1, evaluated in the cycle b is shifted.
  - Next edge: match_pulse=1 for one cycle; match_count+=1, saturating at 2^CNT_W-1.
  - If !overlap: fill <= 0, overriding the increment; hist is still updated.
- Threshold: if thresh!=0 and the post-increment count==thresh, done=1 on the same edge.
  - Remaining bits of the current word still shift, and further hits still count, saturating.
  - No new word is accepted while done=1.
- History and fill persist across word boundaries and IDLE gaps. The stream is continuous.
- cfg_we in IDLE with clear=0:
  - Next edge: latch pattern/overlap/thresh; zero match_count, hist, fill; done=0.
  - in_ready stays valid that cycle. A simultaneous accept is also honoured, and its first bit uses the new config.
- cfg_we outside IDLE: ignored, with no state change.
- clear=1, any state: next edge state=IDLE; shift reg, hist, fill, match_count, done, match_pulse=0. Config registers are retained. in_ready=0 during clear, so clear beats in_valid.
- match_pulse and done are registered. busy = (state==SHIFT).

Test Plan:
- Reset mid-SHIFT: drop reset asynchronously -> all outputs 0 immediately, state IDLE, in_ready=1 after release.
- Config pattern=4'b0110, overlap=1, thresh=0; send 8'b0110_1100 -> match_pulse after bits 4 and 7, match_count=2, busy high exactly 8 cycles.
- Same word with overlap=0 -> single pulse after bit 4, match_count=1.
- Cross-word: send 8'b0000_0011 then 8'b0xxx_xxxx back-to-back (pattern 0110, overlap=1) -> in_ready high on bit_cnt==0 with no idle gap; hit on first bit of second word, match_count=1.
- thresh=2, stream 8'b0110_0110 then offer another word -> done rises with the second pulse, count=2, in_ready stays 0; cfg_we in IDLE restores in_ready=1 and count=0.
- clear asserted together with in_valid mid-SHIFT -> word not accepted, next cycle IDLE, count=0, done=0, config retained; cfg_we during SHIFT shown to have no effect.
